// File: rtl/sev_seg_dec_out.sv
`default_nettype none
// sev_seg_dec_out: bus-loaded output register with a bit-serial binary-to-BCD
// converter driving a multiplexed, sign-aware seven-segment display.
// Revision: 1.0
module sev_seg_dec_out #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1024,
  parameter bit ACTIVE_HIGH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire  [DATA_WIDTH-1:0] bus,
  input  logic                  OI,
  input  logic                  twos_complement,
  output logic                  busy,
  output logic [7:0]            segs,
  output logic [DIGITS-1:0]     sel
);
  localparam int NB = (DATA_WIDTH * 30103 + 99999) / 100000 + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_ZERO  = 8'h3F;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] mag_q;
  logic                  neg_q;
  logic [CW-1:0]         cnt_q;
  logic [4*NB-1:0]       bcd_q;
  logic [4*NB-1:0]       disp_bcd_q;
  logic                  disp_neg_q;
  logic                  disp_ovf_q;
  logic [SW-1:0]         scan_cnt_q;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [7:0]            segs_q, segs_d;
  logic [DIGITS-1:0]     sel_q, sel_d;

  logic                  load_neg;
  logic [DATA_WIDTH-1:0] load_mag;
  logic [4*NB-1:0]       bcd_adj;
  int                    conv_sig;
  logic                  conv_ovf;
  int                    disp_msd;
  int                    scan_pos;
  logic [7:0]            pat;
  logic                  scan_wrap;

  // Most negative value negates to itself, which is exactly its unsigned magnitude.
  assign load_neg = twos_complement & bus[DATA_WIDTH-1];
  assign load_mag = load_neg ? (~bus + 1'b1) : bus;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    conv_sig = 1;
    for (int i = 1; i < NB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) conv_sig = i + 1;
    end
    conv_ovf = (conv_sig + int'(neg_q)) > DIGITS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
    end else if (OI) begin
      state_q <= CONV;
      busy_q  <= 1'b1;
      mag_q   <= load_mag;
      neg_q   <= load_neg;
      cnt_q   <= CW'(DATA_WIDTH);
      bcd_q   <= '0;
    end else begin
      case (state_q)
        CONV: begin
          bcd_q <= {bcd_adj[4*NB-2:0], mag_q[DATA_WIDTH-1]};
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_bcd_q <= bcd_q;
          disp_neg_q <= neg_q;
          disp_ovf_q <= conv_ovf;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [7:0] enc7(input logic [3:0] n);
    case (n)
      4'd0:    enc7 = 8'h3F;
      4'd1:    enc7 = 8'h06;
      4'd2:    enc7 = 8'h5B;
      4'd3:    enc7 = 8'h4F;
      4'd4:    enc7 = 8'h66;
      4'd5:    enc7 = 8'h6D;
      4'd6:    enc7 = 8'h7D;
      4'd7:    enc7 = 8'h07;
      4'd8:    enc7 = 8'h7F;
      4'd9:    enc7 = 8'h6F;
      default: enc7 = 8'h00;
    endcase
  endfunction

  assign scan_wrap = (scan_cnt_q == SW'(SCAN_DIV - 1));

  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_wrap) scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
  end

  // Segments are computed for the digit about to be selected so sel and segs move together.
  always_comb begin
    disp_msd = 0;
    for (int i = 1; i < NB; i++) begin
      if (disp_bcd_q[4*i +: 4] != 4'd0) disp_msd = i;
    end
    scan_pos = int'(scan_idx_d);
    pat      = 8'h00;
    if (disp_ovf_q)                                  pat = SEG_MINUS;
    else if (scan_pos <= disp_msd)                   pat = enc7(disp_bcd_q[4*scan_pos +: 4]);
    else if (disp_neg_q && scan_pos == disp_msd + 1) pat = SEG_MINUS;
    segs_d = ACTIVE_HIGH ? pat : ~pat;
    sel_d  = ACTIVE_HIGH ? (DIGITS'(1) << scan_idx_d) : ~(DIGITS'(1) << scan_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      segs_q     <= ACTIVE_HIGH ? SEG_ZERO : ~SEG_ZERO;
      sel_q      <= ACTIVE_HIGH ? DIGITS'(1) : ~DIGITS'(1);
    end else begin
      scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
      scan_idx_q <= scan_idx_d;
      segs_q     <= segs_d;
      sel_q      <= sel_d;
    end
  end

  assign busy = busy_q;
  assign segs = segs_q;
  assign sel  = sel_q;
endmodule
`default_nettype wire

// File: tb/tb_sev_seg_dec_out.sv
`default_nettype none
// Bench for sev_seg_dec_out: two instances (4 digits active-low, 3 digits active-high)
// compared against a decimal-arithmetic model of the expected display.
module tb_sev_seg_dec_out;
  localparam int DW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          OI = 1'b0;
  logic          tc = 1'b0;
  logic [DW-1:0] bus_drv = '0;
  wire  [DW-1:0] bus;
  logic          busy0, busy1;
  logic [7:0]    segs0, segs1;
  logic [3:0]    sel0;
  logic [2:0]    sel1;

  int errors = 0;
  int checks = 0;

  logic [7:0] enc [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] cap0 [4];
  logic [7:0] cap1 [3];
  bit         bad_sel;

  assign bus = bus_drv;
  always #5 clk = ~clk;

  sev_seg_dec_out #(.DATA_WIDTH(DW), .DIGITS(4), .SCAN_DIV(SD), .ACTIVE_HIGH(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus), .OI(OI), .twos_complement(tc),
    .busy(busy0), .segs(segs0), .sel(sel0)
  );

  sev_seg_dec_out #(.DATA_WIDTH(DW), .DIGITS(3), .SCAN_DIV(SD), .ACTIVE_HIGH(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus), .OI(OI), .twos_complement(tc),
    .busy(busy1), .segs(segs1), .sel(sel1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected segment pattern of digit d for a display of nd digits showing v.
  function automatic logic [7:0] exp_seg(input logic [7:0] v, input bit t, input int nd,
                                         input int d, input bit ah);
    int val, mag, s, q;
    bit neg;
    logic [7:0] p;
    val = (t && v[7]) ? int'(v) - 256 : int'(v);
    neg = (val < 0);
    mag = neg ? -val : val;
    s = 1;
    q = mag;
    while (q >= 10) begin
      q = q / 10;
      s++;
    end
    if (s + int'(neg) > nd) p = 8'h40;
    else if (d < s) begin
      q = mag;
      for (int k = 0; k < d; k++) q = q / 10;
      p = enc[q % 10];
    end else if (neg && d == s) p = 8'h40;
    else p = 8'h00;
    return ah ? p : ~p;
  endfunction

  task automatic load(input logic [7:0] v, input bit t);
    @(negedge clk);
    bus_drv = v;
    tc = t;
    OI = 1'b1;
    @(negedge clk);
    OI = 1'b0;
    bus_drv = 8'($urandom);
    tc = 1'($urandom);
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (busy0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 8'(n), 8'(exp));
  endtask

  task automatic capture();
    for (int d = 0; d < 4; d++) cap0[d] = 'x;
    for (int d = 0; d < 3; d++) cap1[d] = 'x;
    bad_sel = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4 * SD + 4; c++) begin
      logic [3:0] s0;
      s0 = ~sel0;
      if (!$onehot(s0)) bad_sel = 1'b1;
      else for (int d = 0; d < 4; d++) if (s0[d]) cap0[d] = segs0;
      if (!$onehot(sel1)) bad_sel = 1'b1;
      else for (int d = 0; d < 3; d++) if (sel1[d]) cap1[d] = segs1;
      @(negedge clk);
    end
  endtask

  task automatic verify(input string tag, input logic [7:0] v, input bit t);
    int n = 0;
    while ((busy0 || busy1) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("%s idle", tag), 8'(busy0 | busy1), 8'h00);
    capture();
    chk($sformatf("%s sel_onehot", tag), 8'(bad_sel), 8'h00);
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s d0 digit%0d", tag, d), cap0[d], exp_seg(v, t, 4, d, 1'b0));
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s d1 digit%0d", tag, d), cap1[d], exp_seg(v, t, 3, d, 1'b1));
  endtask

  initial begin
    logic [7:0] rv;
    bit rt;
    repeat (2) @(negedge clk);
    chk("reset segs0", segs0, 8'hC0);
    chk("reset sel0", 8'(sel0), 8'h0E);
    chk("reset segs1", segs1, 8'h3F);
    chk("reset sel1", 8'(sel1), 8'h01);
    chk("reset busy0", 8'(busy0), 8'h00);

    rst_n = 1'b1;
    repeat (SD - 1) @(negedge clk);
    chk("scan hold sel0", 8'(sel0), 8'h0E);
    @(negedge clk);
    chk("scan step sel0", 8'(sel0), 8'h0D);
    chk("scan step segs0", segs0, 8'hFF);
    chk("scan step sel1", 8'(sel1), 8'h02);
    chk("scan step segs1", segs1, 8'h00);

    load(8'd255, 1'b0);
    busy_len("busy 255", DW + 1);
    verify("u255", 8'd255, 1'b0);
    load(8'h80, 1'b1);
    verify("s-128", 8'h80, 1'b1);
    load(8'h80, 1'b0);
    verify("u128", 8'h80, 1'b0);
    load(8'h00, 1'b1);
    verify("zero", 8'h00, 1'b1);

    load(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort busy mid", 8'(busy0), 8'h01);
    load(8'h11, 1'b1);
    busy_len("abort busy len", DW + 1);
    verify("abort", 8'h11, 1'b1);

    load(8'h9C, 1'b1);
    verify("ovf -100", 8'h9C, 1'b1);
    load(8'hFF, 1'b1);
    verify("s-1", 8'hFF, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom);
      rt = 1'($urandom);
      load(rv, rt);
      verify($sformatf("rand%0d v=%h t=%0d", i, rv, rt), rv, rt);
    end

    load(8'h77, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy0", 8'(busy0), 8'h00);
    chk("async busy1", 8'(busy1), 8'h00);
    chk("async segs0", segs0, 8'hC0);
    chk("async sel0", 8'(sel0), 8'h0E);
    chk("async segs1", segs1, 8'h3F);
    chk("async sel1", 8'(sel1), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    load(8'd42, 1'b0);
    busy_len("post-reset busy", DW + 1);
    verify("post-reset", 8'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
